// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, HI/LO write and result bus of the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             sig_mthi;
    logic             sig_mtlo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, sig_mthi, sig_mtlo,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, sig_mthi, sig_mtlo,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and restoring divide into HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_hi, acc_lo, b_mag, hi_q, lo_q;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in, quo_s, rem_s;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, is_div, zero_q, done_q, dbz_q;
    logic               sgn, a_neg, b_neg, last;
    logic [WIDTH:0]     mul_sum, rem_try, rem_sub;
    logic [2*WIDTH-1:0] prod, prod_s;

    // acc_hi:acc_lo is the running product for MUL, remainder:quotient for DIV
    always_comb begin
        sgn      = !bus.op[0];
        a_neg    = sgn & bus.src_a[WIDTH-1];
        b_neg    = sgn & bus.src_b[WIDTH-1];
        a_mag_in = a_neg ? -bus.src_a : bus.src_a;
        b_mag_in = b_neg ? -bus.src_b : bus.src_b;
        last     = cnt == CW'(WIDTH - 1);
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
        rem_try  = {acc_hi, acc_lo[WIDTH-1]};
        rem_sub  = rem_try - {1'b0, b_mag};
        prod     = {acc_hi, acc_lo};
        prod_s   = neg_q ? -prod : prod;
        quo_s    = neg_q ? -acc_lo : acc_lo;
        rem_s    = neg_r ? -acc_hi : acc_hi;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start) state_d = !bus.op[1] ? MUL : (bus.src_b == '0 ? FIN : DIV);
            MUL, DIV: if (last) state_d = FIN;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            done_q <= state_q == FIN;
            dbz_q  <= state_q == FIN && zero_q;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        zero_q <= bus.op[1] && bus.src_b == '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_mag  <= b_mag_in;
                        acc_hi <= '0;
                        acc_lo <= a_mag_in;
                        cnt    <= '0;
                    end else begin
                        if (bus.sig_mthi) hi_q <= bus.src_a;
                        if (bus.sig_mtlo) lo_q <= bus.src_a;
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    cnt              <= cnt + 1'b1;
                end
                DIV: begin
                    acc_hi <= rem_sub[WIDTH] ? rem_try[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], !rem_sub[WIDTH]};
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                    if (!zero_q) begin
                        hi_q <= is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                        lo_q <= is_div ? quo_s : prod_s[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors, corner sequences and randomized ops against a
// plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        int lat; int nbusy; logic [W-1:0] h; logic [W-1:0] l; logic z; logic idle; logic single;
    } res_t;

    typedef struct {
        string nm; logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b;
        logic [W-1:0] pre_hi; logic [W-1:0] pre_lo;
        logic [W-1:0] exp_hi; logic [W-1:0] exp_lo; logic exp_z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic; SV division truncates toward zero, % follows the dividend
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [W-1:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o[1]) begin
            p = o[0] ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, m_hi, m_lo};
        if (o[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
        return {1'b0, r, q};
    endfunction

    task automatic mt(input bit wh, input bit wl, input logic [W-1:0] d);
        @(negedge clk);
        bus.start = 1'b0; bus.sig_mthi = wh; bus.sig_mtlo = wl; bus.src_a = d;
        @(posedge clk); #1;
        bus.sig_mthi = 1'b0; bus.sig_mtlo = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output res_t r);
        @(negedge clk);
        bus.op = o; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
        bus.sig_mthi = 1'b0; bus.sig_mtlo = 1'b0;
        @(posedge clk); #1;
        r.lat = 1; r.nbusy = 0;
        bus.start = 1'b0;
        while (!bus.done && r.lat < 100) begin
            if (bus.busy) r.nbusy++;
            if (noise) begin
                bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
                bus.start = 1'($urandom); bus.sig_mthi = 1'($urandom); bus.sig_mtlo = 1'($urandom);
            end
            @(posedge clk); #1;
            r.lat++;
        end
        bus.start = 1'b0; bus.sig_mthi = 1'b0; bus.sig_mtlo = 1'b0;
        r.h = bus.hi; r.l = bus.lo; r.z = bus.div_by_zero; r.idle = !bus.busy;
        @(posedge clk); #1;
        r.single = !bus.done && !bus.div_by_zero;
    endtask

    task automatic compare_res(input string nm, input res_t r, input logic [W-1:0] eh,
                               input logic [W-1:0] el, input logic ez);
        chk({nm, " latency"}, 64'(r.lat), ez ? 64'd2 : 64'(W + 2));
        chk({nm, " busy_cycles"}, 64'(r.nbusy), ez ? 64'd1 : 64'(W + 1));
        chk({nm, " hi"}, 64'(r.h), 64'(eh));
        chk({nm, " lo"}, 64'(r.l), 64'(el));
        chk({nm, " div_by_zero"}, 64'(r.z), 64'(ez));
        chk({nm, " idle_at_done"}, 64'(r.idle), 64'd1);
        chk({nm, " done_single"}, 64'(r.single), 64'd1);
    endtask

    initial begin
        res_t r;
        logic [2*W:0] e;
        logic [1:0] o;
        logic [W-1:0] a, b;
        int lat, ndone;

        vecs.push_back('{"mult_2e9x3",   2'b00, 32'd2000000000, 32'd3,    '0, '0, 32'h00000001, 32'h65a0bc00, 1'b0});
        vecs.push_back('{"multu_m1xm1",  2'b01, 32'hffffffff, 32'hffffffff, '0, '0, 32'hfffffffe, 32'h00000001, 1'b0});
        vecs.push_back('{"mult_m1xm1",   2'b00, 32'hffffffff, 32'hffffffff, '0, '0, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{"mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, '0, '0, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{"mult_m1x5",    2'b00, 32'hffffffff, 32'd5,        '0, '0, 32'hffffffff, 32'hfffffffb, 1'b0});
        vecs.push_back('{"div_m11_3",    2'b10, 32'hfffffff5, 32'd3,        '0, '0, 32'hfffffffe, 32'hfffffffd, 1'b0});
        vecs.push_back('{"divu_11_3",    2'b11, 32'd11,       32'd3,        '0, '0, 32'h00000002, 32'h00000003, 1'b0});
        vecs.push_back('{"div_min_m1",   2'b10, 32'h80000000, 32'hffffffff, '0, '0, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{"div_7_m2",     2'b10, 32'd7,        32'hfffffffe, '0, '0, 32'h00000001, 32'hfffffffd, 1'b0});
        vecs.push_back('{"divu_5_0",     2'b11, 32'd5,        32'd0, 32'h12345678, 32'haaaa5555, 32'h12345678, 32'haaaa5555, 1'b1});
        vecs.push_back('{"div_7_0",      2'b10, 32'd7,        32'd0, 32'h0badf00d, 32'hffffffff, 32'h0badf00d, 32'hffffffff, 1'b1});

        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.sig_mthi = 1'b0; bus.sig_mtlo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        mt(1'b1, 1'b1, 32'hdeadbeef);
        chk("mthi_mtlo_both hi", 64'(bus.hi), 64'hdeadbeef);
        chk("mthi_mtlo_both lo", 64'(bus.lo), 64'hdeadbeef);

        for (int i = 0; i < vecs.size(); i++) begin
            mt(1'b1, 1'b0, vecs[i].pre_hi);
            mt(1'b0, 1'b1, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i % 2) == 1, r);
            compare_res(vecs[i].nm, r, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_z);
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // start wins over simultaneous HI/LO writes; a zero-divisor op keeps HI/LO visible
        mt(1'b1, 1'b0, 32'd1);
        mt(1'b0, 1'b1, 32'd2);
        @(negedge clk);
        bus.op = 2'b11; bus.src_a = 32'd99; bus.src_b = '0;
        bus.start = 1'b1; bus.sig_mthi = 1'b1; bus.sig_mtlo = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.sig_mthi = 1'b0; bus.sig_mtlo = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("start_priority latency", 64'(lat), 64'd2);
        chk("start_priority hi", 64'(bus.hi), 64'd1);
        chk("start_priority lo", 64'(bus.lo), 64'd2);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) mt(1'($urandom), 1'($urandom), $urandom);
            o = 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'hffffffff;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            e = model(o, a, b);
            run_op(o, a, b, 1'b1, r);
            compare_res($sformatf("rand%0d op%0d %h/%h", i, o, a, b), r, e[2*W-1:W], e[W-1:0], e[2*W]);
            m_hi = e[2*W-1:W];
            m_lo = e[W-1:0];
        end

        @(negedge clk);
        bus.op = 2'b00; bus.src_a = 32'd2000000000; bus.src_b = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            bus.start = lat == 4;
            if (lat == 4) begin
                bus.src_a = 32'd5; bus.src_b = 32'd7;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("start_while_busy latency", 64'(lat), 64'(W + 2));
        chk("start_while_busy hi", 64'(bus.hi), 64'h00000001);
        chk("start_while_busy lo", 64'(bus.lo), 64'h65a0bc00);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("start_while_busy extra_done", 64'(ndone), 64'd0);

        mt(1'b1, 1'b0, 32'h11111111);
        mt(1'b0, 1'b1, 32'h22222222);
        @(negedge clk);
        bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset hi", 64'(bus.hi), 64'd0);
        chk("mid_reset lo", 64'(bus.lo), 64'd0);
        chk("mid_reset busy", 64'(bus.busy), 64'd0);
        chk("mid_reset done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("mid_reset no_done", 64'(ndone), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, r);
        compare_res("after_reset divu_100_7", r, 32'd2, 32'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 32, giving the operand width and the width of each of HI and LO.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 src_a  input  WIDTH  multiplicand or dividend; also the write data for sig_mthi and sig_mtlo.
REQ-007 src_b  input  WIDTH  multiplier or divisor.
REQ-008 sig_mthi  input  1  write src_a into HI.
REQ-009 sig_mtlo  input  1  write src_a into LO.
REQ-010 busy  output  1  high while an operation is in flight; the pipeline stalls HI/LO readers on it.
REQ-011 done  output  1  one-cycle pulse in the cycle new HI/LO values first become visible.
REQ-012 div_by_zero  output  1  one-cycle pulse, coincident with done, for a DIV or DIVU with src_b=0.
REQ-013 hi, lo  output  WIDTH each  registered HI/LO architectural registers.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and FIN; busy SHALL be 1 in MUL, DIV and FIN, and 0 in IDLE.
REQ-015 In IDLE with start=1, the block SHALL latch op, src_a and src_b, then go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 Operand changes while busy=1 SHALL NOT affect the result.
REQ-017 For signed ops, the block SHALL convert operands to magnitudes, iterate unsigned, and restore the result sign in FIN.
REQ-018 MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles, producing a 2*WIDTH-bit product.
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles.
REQ-020 MUL and DIV SHALL each go to FIN after their WIDTH iteration cycles.
REQ-021 FIN SHALL last one cycle and write the result: multiply gives hi=product[2W-1:W], lo=product[W-1:0]; divide gives lo=quotient, hi=remainder.
REQ-022 FIN SHALL pulse done, then return to IDLE.
REQ-023 Result latency SHALL be WIDTH+2 rising edges from the start-accept edge to the edge that makes hi/lo/done visible (34 for WIDTH=32), with busy=1 for WIDTH+1 cycles.
REQ-024 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-025 Signed division of the most negative value by -1 SHALL give lo = most negative value and hi = 0, with no error flag.
REQ-026 A DIV or DIVU with src_b=0 SHALL skip iteration and go straight from IDLE to FIN; FIN SHALL pulse done and div_by_zero, leave hi/lo unchanged, and return to IDLE.
REQ-027 Signed multiplication SHALL be exact across the full 2*WIDTH result, with no overflow.
REQ-028 sig_mthi and sig_mtlo SHALL write src_a into hi or lo on the next edge, only in IDLE with start=0; both may be asserted in the same cycle.
REQ-029 While busy=1, start, sig_mthi and sig_mtlo SHALL be ignored, with no queuing.
REQ-030 In IDLE with start=1, start SHALL take priority over sig_mthi and sig_mtlo, and the writes SHALL be dropped.
REQ-031 hi and lo SHALL change only in FIN, on a sig_mthi/sig_mtlo write, or on reset.

Reset
REQ-032 On reset=1 at a clock edge, the state SHALL go to IDLE, and hi, lo, busy, done and div_by_zero SHALL all be 0.
REQ-033 Reset SHALL take priority over every other input.
REQ-034 Reset during MUL, DIV or FIN SHALL abort the operation with no done pulse, and the partial result SHALL be discarded.

Verification (WIDTH=32)
REQ-035 MULT, src_a=2000000000, src_b=3: 34 edges after accept, hi=00000001, lo=65a0bc00, done=1 for exactly one cycle; busy=1 for the 33 preceding cycles.
REQ-036 MULTU ffffffff x ffffffff gives hi=fffffffe, lo=00000001. MULT with the same operands (-1 x -1) gives hi=00000000, lo=00000001.
REQ-037 DIV -11/3 gives lo=fffffffd, hi=fffffffe. DIVU 11/3 gives lo=3, hi=2. DIV 80000000/ffffffff gives lo=80000000, hi=0.
REQ-038 Divide-by-zero: sig_mthi with src_a=12345678, then DIVU 5/0 → done and div_by_zero both pulse 2 edges after accept; hi stays 12345678.
REQ-039 Start while busy: MULT is accepted, then start is reasserted with new operands at cycle 5 → ignored; the first result appears on schedule and no second done occurs.
REQ-040 Mid-operation reset: reset is asserted 10 cycles into a DIV → next cycle hi=lo=0 and busy=0, and no done pulse occurs; a new start is then accepted normally.
